regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised register file for the pipelined datapath: 2 combinational read ports, 1 synchronous write port.
- Integrated per-register scoreboard (busy bits) so decode can detect RAW hazards against in-flight producers.
- Optional write-to-read bypass for same-cycle writeback.
- Sits in ID stage; write port driven by WB stage, issue port by ID stage on instruction issue.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ReadReg1  input  ADDR_W  read port 1 index
ReadReg2  input  ADDR_W  read port 2 index
readData1  output  DATA_W  read port 1 data (combinational)
readData2  output  DATA_W  read port 2 data (combinational)
busy1  output  1  scoreboard status of ReadReg1
busy2  output  1  scoreboard status of ReadReg2
WriteReg  input  ADDR_W  write index
writeData  input  DATA_W  write data
regWrite  input  1  write enable
issueReg  input  ADDR_W  destination of instruction issuing this cycle
issueValid  input  1  mark issueReg pending
flush  input  1  clear all busy bits (pipeline squash)
pendingCount  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset: rst high clears all registers to 0 and all busy bits to 0, immediately and asynchronously, including mid-write or mid-issue. Outputs while in reset: readData* = 0, busy* = 0, pendingCount = 0. First update occurs on the first rising edge after rst deasserts.
- Write: on posedge, if regWrite and not (ZERO_REG and WriteReg==0), mem[WriteReg] <= writeData. Otherwise no change.
- Read: readDataN = mem[ReadRegN].
  - If ZERO_REG and ReadRegN==0: readDataN = 0.
  - Else if BYPASS and regWrite and WriteReg==ReadRegN: readDataN = writeData (same cycle).
  - Both ports bypass independently; equal addresses on both ports return identical data.
- Scoreboard, per register r, updated on posedge in priority order:
  1. Clear: flush clears all bits; otherwise, if regWrite and WriteReg==r, clear bit r.
  2. Set: if issueValid and issueReg==r, set bit r. Set wins over clear, including flush in the same cycle (new producer supersedes old writeback).
  - Register 0 never set when ZERO_REG=1.
  - Setting an already-busy register leaves it busy; no count of producers, so the first writeback clears it.
- busyN = busy[ReadRegN], except:
  - with BYPASS=1, forced 0 when regWrite and WriteReg==ReadRegN (data is available via bypass);
  - always 0 for register 0 when ZERO_REG=1.
  - busyN does not reflect same-cycle issueValid (the bit is visible the next cycle).
- pendingCount = popcount of busy vector (registered state, combinational sum). Range 0..2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG.
- Latency: write visible at read port next cycle (same cycle if BYPASS=1). Busy set/clear visible next cycle.
- Widths are exact; no sign extension or truncation of data.

Test Plan:
1. Reset clears state: preload x5=0xDEADBEEF, assert rst mid-cycle -> readData1(ReadReg1=5)=0 immediately; pendingCount=0.
2. Bypass, BYPASS=1: regWrite=1, WriteReg=7, writeData=0x12345678, ReadReg1=ReadReg2=7 -> both read 0x12345678 in the same cycle.
   - BYPASS=0, same stimulus -> old value 0 this cycle, 0x12345678 next cycle.
3. Zero register, ZERO_REG=1: write x0=0xFFFFFFFF and issueValid with issueReg=0 -> readData1=0, busy1=0, pendingCount=0 next cycle.
4. Scoreboard basic: issue x3 -> next cycle busy1(ReadReg1=3)=1, pendingCount=1. Write x3=0xA5 -> busy1=0 during the write cycle (BYPASS=1), readData1=0xA5, pendingCount=0 after the edge.
5. Set-wins collision: x4 busy; in one cycle regWrite WriteReg=4 plus issueValid issueReg=4 -> next cycle busy for x4 remains 1 and mem[4] updated.
6. Flush: issue x1, x2, x9 over 3 cycles (pendingCount=3). Then flush with issueValid issueReg=6 -> next cycle pendingCount=1, only x6 busy, register data unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, one synchronous
// write port, and a per-register busy scoreboard for RAW hazard detection.
// Same-cycle writeback can optionally be forwarded to the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] issueReg,
    input  logic              issueValid,
    input  logic              flush,
    output logic [ADDR_W:0]   pendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic              wr_en;
    logic              iss_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];
    logic [ADDR_W:0]   pend_cnt;

    // Writes and issues aimed at a hardwired-zero register 0 are dropped.
    always_comb begin
        wr_en  = regWrite   && !(ZERO_REG && (WriteReg == '0));
        iss_en = issueValid && !(ZERO_REG && (issueReg == '0));
    end

    // Next register contents: single write port.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[WriteReg] = writeData;
        end
    end

    // Next scoreboard: clear (flush or writeback) first, then issue set so a
    // new producer supersedes the old writeback in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else if (regWrite) begin
            busy_d[WriteReg] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issueReg] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: zero register, then bypass of the writeback, then storage.
    // A bypassed register is reported not busy since its data is on the port.
    always_comb begin
        rd_addr[0] = ReadReg1;
        rd_addr[1] = ReadReg2;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (rst) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if (ZERO_REG && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if (BYPASS && regWrite && (WriteReg == rd_addr[p])) begin
                rd_data[p] = writeData;
                rd_busy[p] = 1'b0;
            end else begin
                rd_data[p] = mem_q[rd_addr[p]];
                rd_busy[p] = busy_q[rd_addr[p]];
            end
        end
    end

    // Number of in-flight producers: popcount of the registered busy vector.
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + {{ADDR_W{1'b0}}, busy_q[i]};
        end
    end

    // Output mapping.
    always_comb begin
        readData1    = rd_data[0];
        readData2    = rd_data[1];
        busy1        = rd_busy[0];
        busy2        = rd_busy[1];
        pendingCount = pend_cnt;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two register files (bypass on and off) with directed
// and random stimulus; an array-based model predicts every output and a
// negedge monitor checks the DUTs against the queued predictions.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0, issueReg = '0;
    logic [DW-1:0] writeData = '0;
    logic          regWrite = 1'b0, issueValid = 1'b0, flush = 1'b0;

    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          b1_b, b2_b, b1_n, b2_n;
    logic [AW:0]   pc_b, pc_n;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .readData1(rd1_b), .readData2(rd2_b), .busy1(b1_b), .busy2(b2_b),
        .WriteReg(WriteReg), .writeData(writeData), .regWrite(regWrite),
        .issueReg(issueReg), .issueValid(issueValid), .flush(flush),
        .pendingCount(pc_b));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .readData1(rd1_n), .readData2(rd2_n), .busy1(b1_n), .busy2(b2_n),
        .WriteReg(WriteReg), .writeData(writeData), .regWrite(regWrite),
        .issueReg(issueReg), .issueValid(issueValid), .flush(flush),
        .pendingCount(pc_n));

    always #5 clk = ~clk;

    // Reference model: architectural register contents and pending set.
    logic [DW-1:0] m_mem [NR];
    bit            m_busy [NR];

    typedef struct {
        logic [DW-1:0] d1, d2, nd1, nd2;
        logic          b1, b2, nb1, nb2;
        logic [AW:0]   pc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // What a read port should show for address a given the current inputs.
    function automatic void model_port(input logic [AW-1:0] a, input bit bp,
                                       output logic [DW-1:0] d, output logic b);
        if (rst || a == 0) begin
            d = '0; b = 1'b0;
        end else if (bp && regWrite && WriteReg == a) begin
            d = writeData; b = 1'b0;
        end else begin
            d = m_mem[a]; b = m_busy[a];
        end
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   cnt = 0;
        model_port(ReadReg1, 1'b1, e.d1, e.b1);
        model_port(ReadReg2, 1'b1, e.d2, e.b2);
        model_port(ReadReg1, 1'b0, e.nd1, e.nb1);
        model_port(ReadReg2, 1'b0, e.nd2, e.nb2);
        for (int i = 0; i < NR; i++) cnt += int'(m_busy[i]);
        e.pc = (AW+1)'(cnt);
        return e;
    endfunction

    // Clock-edge effect of the currently applied inputs.
    function automatic void model_edge();
        if (rst) return;
        if (flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (regWrite) begin
            m_busy[WriteReg] = 1'b0;
        end
        if (issueValid && issueReg != 0) m_busy[issueReg] = 1'b1;
        if (regWrite && WriteReg != 0) m_mem[WriteReg] = writeData;
    endfunction

    task automatic drive(input bit rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input bit iv, input logic [AW-1:0] ir, input bit fl,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(posedge clk);
        model_edge();
        #1;
        regWrite = rw; WriteReg = wr; writeData = wd;
        issueValid = iv; issueReg = ir; flush = fl;
        ReadReg1 = r1; ReadReg2 = r2;
        exp_q.push_back(model_expect());
    endtask

    // Reset asserted mid-cycle while a write and an issue are being presented.
    task automatic do_reset(input logic [AW-1:0] r1);
        @(posedge clk);
        model_edge();
        #2;
        ReadReg1 = r1; ReadReg2 = r1;
        rst = 1'b1;
        model_clear();
        exp_q.push_back(model_expect());
        @(posedge clk);
        #1;
        regWrite = 1'b0; issueValid = 1'b0; flush = 1'b0;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare whenever a prediction is outstanding, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bp_readData1", rd1_b, e.d1);
            chk("bp_readData2", rd2_b, e.d2);
            chk("bp_busy1", 32'(b1_b), 32'(e.b1));
            chk("bp_busy2", 32'(b2_b), 32'(e.b2));
            chk("bp_pendingCount", 32'(pc_b), 32'(e.pc));
            chk("nb_readData1", rd1_n, e.nd1);
            chk("nb_readData2", rd2_n, e.nd2);
            chk("nb_busy1", 32'(b1_n), 32'(e.nb1));
            chk("nb_busy2", 32'(b2_n), 32'(e.nb2));
            chk("nb_pendingCount", 32'(pc_n), 32'(e.pc));
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset clears stored data and pending state.
        drive(1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5);
        drive(0, 0, 0, 1, 11, 0, 5, 11);
        drive(1, 5, 32'h0BADF00D, 1, 12, 0, 5, 11);
        do_reset(5);
        drive(0, 0, 0, 0, 0, 0, 5, 11);

        // Bypass vs stored value on the same write.
        drive(1, 7, 32'h12345678, 0, 0, 0, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 7);

        // Register 0 is never written nor marked busy.
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Issue then writeback clears the busy bit.
        drive(0, 0, 0, 1, 3, 0, 3, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        drive(1, 3, 32'h000000A5, 0, 0, 0, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 3, 0);

        // Issue and writeback to the same register: issue wins.
        drive(0, 0, 0, 1, 4, 0, 4, 0);
        drive(1, 4, 32'h55AA55AA, 1, 4, 0, 4, 4);
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        drive(1, 4, 32'h00000044, 0, 0, 0, 4, 0);

        // Flush with a simultaneous issue keeps only the new producer.
        drive(0, 0, 0, 1, 1, 0, 1, 2);
        drive(0, 0, 0, 1, 2, 0, 1, 2);
        drive(0, 0, 0, 1, 9, 0, 9, 1);
        drive(0, 0, 0, 1, 6, 1, 1, 9);
        drive(0, 0, 0, 0, 0, 0, 6, 4);
        drive(0, 0, 0, 0, 0, 0, 3, 7);

        // Random traffic over a narrow address range for frequent collisions.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(5'($urandom_range(0, 31)));
            end else begin
                drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 11)), $urandom,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 11)),
                      $urandom_range(0, 24) == 0,
                      5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
            end
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
